// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared RV32I definitions for the execute/memory stage:
//   - opcode, funct3 and funct7 encodings decoded in EX
//   - bit positions of the pipeline hold/flush vector and its three encodings
//   - field layout of the ID/EX control word
//   - machine word width (XLEN)
package riscv_pkg;

  localparam int XLEN           = 32;

  // ID/EX control word: bit 0 marks a real instruction, the rest is reserved
  localparam int CTRL_W         = 4;
  localparam int CTRL_VALID_BIT = 0;

  // Hold/flush vector bit positions
  localparam int HOLD_W              = 4;
  localparam int HOLD_BIT_PC_HOLD    = 3;
  localparam int HOLD_BIT_IFID_HOLD  = 2;
  localparam int HOLD_BIT_IFID_FLUSH = 1;
  localparam int HOLD_BIT_IDEX_FLUSH = 0;

  localparam logic [HOLD_W-1:0] HOLD_NONE = 4'b0000;
  localparam logic [HOLD_W-1:0] HOLD_JUMP = (4'b0001 << HOLD_BIT_IFID_FLUSH)
                                          | (4'b0001 << HOLD_BIT_IDEX_FLUSH);
  localparam logic [HOLD_W-1:0] HOLD_HALT = (4'b0001 << HOLD_BIT_PC_HOLD)
                                          | (4'b0001 << HOLD_BIT_IFID_HOLD)
                                          | (4'b0001 << HOLD_BIT_IDEX_FLUSH);

  // Major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // ALU funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Load/store width funct3
  localparam logic [2:0] F3_B    = 3'b000;
  localparam logic [2:0] F3_H    = 3'b001;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BU   = 3'b100;
  localparam logic [2:0] F3_HU   = 3'b101;

  // funct7
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/ex_data_ram.sv
// ex_data_ram
//   DEPTH x 32-bit data RAM: asynchronous read, synchronous write.
//   Contents are not reset.
//   Ports: i_clk (write clock), i_we (write enable), i_addr (word index),
//          i_wdata (write word), o_rdata (word at i_addr, combinational).
module ex_data_ram #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] mem_q [DEPTH];

  // Word write on the rising edge
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_addr];

endmodule

// File: rtl/ex_mem_unit.sv
// ex_mem_unit
//   RV32I execute stage with integrated data RAM and hold/flush control.
//   Everything except the RAM write is combinational; a store's
//   read-modify-write merge happens in the same cycle and commits on i_Clk.
//   Inputs : i_Clk, i_reset (async, active low), i_pc_addr, i_inst_data,
//            i_reg1_data, i_reg2_data, i_regd_addr, i_imm_data, i_ctrl[0]=valid
//   Outputs: o_regd_we/o_regd_w_addr/o_regd_w_data (register write port),
//            o_hold_flag {PC hold, IF/ID hold, IF/ID flush, ID/EX flush},
//            o_jump_flag/o_jump_addr (PC redirect)
//   Build option: MISALIGN_HALT_EN -- misaligned half/word accesses halt
//   instead of being force-aligned.
module ex_mem_unit
  import riscv_pkg::*;
#(
  parameter int RAM_DEPTH = 4096,
  parameter int RAM_AW    = 12
) (
  input  logic              i_Clk,
  input  logic              i_reset,
  input  logic [XLEN-1:0]   i_pc_addr,
  input  logic [XLEN-1:0]   i_inst_data,
  input  logic [XLEN-1:0]   i_reg1_data,
  input  logic [XLEN-1:0]   i_reg2_data,
  input  logic [4:0]        i_regd_addr,
  input  logic [XLEN-1:0]   i_imm_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_regd_we,
  output logic [4:0]        o_regd_w_addr,
  output logic [XLEN-1:0]   o_regd_w_data,
  output logic [HOLD_W-1:0] o_hold_flag,
  output logic              o_jump_flag,
  output logic [XLEN-1:0]   o_jump_addr
);

  logic              valid_s;
  logic [6:0]        opcode_s;
  logic [2:0]        funct3_s;
  logic [6:0]        funct7_s;
  logic [XLEN-1:0]   ea_s;
  logic [XLEN-1:0]   pc_plus4_s;
  logic [XLEN-1:0]   alu_b_s;
  logic [4:0]        shamt_s;
  logic [XLEN-1:0]   alu_res_s;
  logic              alu_legal_s;
  logic [1:0]        off_s;
  logic              misalign_s;
  logic [XLEN-1:0]   ram_rdata_s;
  logic [XLEN-1:0]   lane_s;
  logic [XLEN-1:0]   load_data_s;
  logic [XLEN-1:0]   st_mask_s;
  logic [XLEN-1:0]   ram_wdata_s;
  logic [RAM_AW-1:0] ram_addr_s;
  logic              ram_we_s;
  logic              rd_we_s;
  logic [XLEN-1:0]   rd_data_s;
  logic              store_s;
  logic              br_taken_s;
  logic              jump_s;
  logic [XLEN-1:0]   jump_tgt_s;
  logic              halt_s;
  logic              unused_s;

  assign valid_s    = i_reset & i_ctrl[CTRL_VALID_BIT];
  assign opcode_s   = i_inst_data[6:0];
  assign funct3_s   = i_inst_data[14:12];
  assign funct7_s   = i_inst_data[31:25];
  assign ea_s       = i_reg1_data + i_imm_data;
  assign pc_plus4_s = i_pc_addr + 32'd4;
  // Upper address bits alias onto the RAM
  assign ram_addr_s = ea_s[RAM_AW+1:2];
  assign ram_we_s   = valid_s & store_s;
  // Register indices come from ID, not from the instruction word here
  assign unused_s   = ^{i_inst_data[24:7], i_ctrl[CTRL_W-1:1], ea_s[XLEN-1:RAM_AW+2]};

  ex_data_ram #(
    .DEPTH (RAM_DEPTH),
    .AW    (RAM_AW)
  ) u_ram (
    .i_clk   (i_Clk),
    .i_we    (ram_we_s),
    .i_addr  (ram_addr_s),
    .i_wdata (ram_wdata_s),
    .o_rdata (ram_rdata_s)
  );

  // ALU for OP and OP-IMM; SUB only exists in the register form
  always_comb begin
    alu_b_s   = (opcode_s == OPC_OP) ? i_reg2_data : i_imm_data;
    shamt_s   = alu_b_s[4:0];
    alu_res_s = 32'd0;
    case (funct3_s)
      F3_ADD: begin
        if ((opcode_s == OPC_OP) && funct7_s[5]) begin
          alu_res_s = i_reg1_data - alu_b_s;
        end else begin
          alu_res_s = i_reg1_data + alu_b_s;
        end
      end
      F3_SLL:  alu_res_s = i_reg1_data << shamt_s;
      F3_SLT:  alu_res_s = {31'd0, $signed(i_reg1_data) < $signed(alu_b_s)};
      F3_SLTU: alu_res_s = {31'd0, i_reg1_data < alu_b_s};
      F3_XOR:  alu_res_s = i_reg1_data ^ alu_b_s;
      F3_SR: begin
        if (funct7_s[5]) begin
          alu_res_s = $unsigned($signed(i_reg1_data) >>> shamt_s);
        end else begin
          alu_res_s = i_reg1_data >> shamt_s;
        end
      end
      F3_OR:   alu_res_s = i_reg1_data | alu_b_s;
      F3_AND:  alu_res_s = i_reg1_data & alu_b_s;
      default: alu_res_s = 32'd0;
    endcase
  end

  // funct7 legality: only the shift encodings of OP-IMM constrain funct7
  always_comb begin
    alu_legal_s = 1'b1;
    if (opcode_s == OPC_OP) begin
      alu_legal_s = (funct7_s == F7_BASE)
                 || ((funct7_s == F7_ALT) && ((funct3_s == F3_ADD) || (funct3_s == F3_SR)));
    end else if (funct3_s == F3_SLL) begin
      alu_legal_s = (funct7_s == F7_BASE);
    end else if (funct3_s == F3_SR) begin
      alu_legal_s = (funct7_s == F7_BASE) || (funct7_s == F7_ALT);
    end else begin
      alu_legal_s = 1'b1;
    end
  end

  // Byte offset inside the word, with half/word accesses forced aligned
  always_comb begin
    case (funct3_s)
      F3_H, F3_HU: off_s = {ea_s[1], 1'b0};
      F3_W:        off_s = 2'b00;
      default:     off_s = ea_s[1:0];
    endcase
  end

`ifdef MISALIGN_HALT_EN
  // Misaligned half/word accesses are refused and halt the pipeline
  always_comb begin
    case (funct3_s)
      F3_H, F3_HU: misalign_s = ea_s[0];
      F3_W:        misalign_s = (ea_s[1:0] != 2'b00);
      default:     misalign_s = 1'b0;
    endcase
  end
`else
  assign misalign_s = 1'b0;
`endif

  assign lane_s = ram_rdata_s >> {off_s, 3'b000};

  // Load extract: pick the addressed byte/half and extend it
  always_comb begin
    case (funct3_s)
      F3_B:    load_data_s = {{24{lane_s[7]}}, lane_s[7:0]};
      F3_H:    load_data_s = {{16{lane_s[15]}}, lane_s[15:0]};
      F3_W:    load_data_s = lane_s;
      F3_BU:   load_data_s = {24'd0, lane_s[7:0]};
      F3_HU:   load_data_s = {16'd0, lane_s[15:0]};
      default: load_data_s = 32'd0;
    endcase
  end

  // Store merge: only the selected lanes of the current word change
  always_comb begin
    case (funct3_s)
      F3_B:    st_mask_s = 32'h0000_00FF << {off_s, 3'b000};
      F3_H:    st_mask_s = 32'h0000_FFFF << {off_s, 3'b000};
      default: st_mask_s = 32'hFFFF_FFFF;
    endcase
    ram_wdata_s = (ram_rdata_s & ~st_mask_s) | ((i_reg2_data << {off_s, 3'b000}) & st_mask_s);
  end

  // Main decode: write-back selection, branch resolution, halt detection
  always_comb begin
    rd_we_s    = 1'b0;
    rd_data_s  = 32'd0;
    store_s    = 1'b0;
    br_taken_s = 1'b0;
    jump_s     = 1'b0;
    jump_tgt_s = 32'd0;
    halt_s     = 1'b0;
    case (opcode_s)
      OPC_LUI: begin
        rd_we_s   = 1'b1;
        rd_data_s = i_imm_data;
      end
      OPC_AUIPC: begin
        rd_we_s   = 1'b1;
        rd_data_s = i_pc_addr + i_imm_data;
      end
      OPC_JAL: begin
        rd_we_s    = 1'b1;
        rd_data_s  = pc_plus4_s;
        jump_s     = 1'b1;
        jump_tgt_s = i_pc_addr + i_imm_data;
      end
      OPC_JALR: begin
        if (funct3_s == 3'b000) begin
          rd_we_s    = 1'b1;
          rd_data_s  = pc_plus4_s;
          jump_s     = 1'b1;
          jump_tgt_s = ea_s & ~32'd1;
        end else begin
          halt_s = 1'b1;
        end
      end
      OPC_BRANCH: begin
        case (funct3_s)
          F3_BEQ:  br_taken_s = (i_reg1_data == i_reg2_data);
          F3_BNE:  br_taken_s = (i_reg1_data != i_reg2_data);
          F3_BLT:  br_taken_s = ($signed(i_reg1_data) < $signed(i_reg2_data));
          F3_BGE:  br_taken_s = ($signed(i_reg1_data) >= $signed(i_reg2_data));
          F3_BLTU: br_taken_s = (i_reg1_data < i_reg2_data);
          F3_BGEU: br_taken_s = (i_reg1_data >= i_reg2_data);
          default: halt_s = 1'b1;
        endcase
        jump_s     = br_taken_s;
        jump_tgt_s = i_pc_addr + i_imm_data;
      end
      OPC_LOAD: begin
        case (funct3_s)
          F3_B, F3_H, F3_W, F3_BU, F3_HU: begin
            if (misalign_s) begin
              halt_s = 1'b1;
            end else begin
              rd_we_s   = 1'b1;
              rd_data_s = load_data_s;
            end
          end
          default: halt_s = 1'b1;
        endcase
      end
      OPC_STORE: begin
        case (funct3_s)
          F3_B, F3_H, F3_W: begin
            if (misalign_s) begin
              halt_s = 1'b1;
            end else begin
              store_s = 1'b1;
            end
          end
          default: halt_s = 1'b1;
        endcase
      end
      OPC_OP_IMM, OPC_OP: begin
        if (alu_legal_s) begin
          rd_we_s   = 1'b1;
          rd_data_s = alu_res_s;
        end else begin
          halt_s = 1'b1;
        end
      end
      OPC_FENCE, OPC_SYSTEM: halt_s = 1'b1;
      default:               halt_s = 1'b1;
    endcase
  end

  // Hold/flush priority (reset > jump > halt) and the register write port
  always_comb begin
    if (!valid_s) begin
      o_hold_flag = HOLD_NONE;
      o_jump_flag = 1'b0;
      o_jump_addr = 32'd0;
    end else if (jump_s) begin
      o_hold_flag = HOLD_JUMP;
      o_jump_flag = 1'b1;
      o_jump_addr = jump_tgt_s;
    end else if (halt_s) begin
      o_hold_flag = HOLD_HALT;
      o_jump_flag = 1'b0;
      o_jump_addr = 32'd0;
    end else begin
      o_hold_flag = HOLD_NONE;
      o_jump_flag = 1'b0;
      o_jump_addr = 32'd0;
    end
    if (valid_s && rd_we_s && (i_regd_addr != 5'd0)) begin
      o_regd_we     = 1'b1;
      o_regd_w_addr = i_regd_addr;
      o_regd_w_data = rd_data_s;
    end else begin
      o_regd_we     = 1'b0;
      o_regd_w_addr = 5'd0;
      o_regd_w_data = 32'd0;
    end
  end

endmodule

// File: tb/tb_ex_mem_unit.sv
// tb_ex_mem_unit
//   Directed plus randomized check of ex_mem_unit against a mnemonic-level
//   reference model with a byte-addressed memory image.
module tb_ex_mem_unit;

`ifdef MISALIGN_HALT_EN
  localparam bit MIS_HALT = 1'b1;
`else
  localparam bit MIS_HALT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc, inst, rs1, rs2, imm;
  logic [4:0]  rd;
  logic [3:0]  ctrl;
  logic        o_we;
  logic [4:0]  o_wa;
  logic [31:0] o_wd;
  logic [3:0]  o_hold;
  logic        o_jmp;
  logic [31:0] o_jaddr;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mb [0:16383];

  typedef enum int {
    M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA, M_OR, M_AND,
    M_ADDI, M_SLTI, M_SLTIU, M_XORI, M_ORI, M_ANDI, M_SLLI, M_SRLI, M_SRAI,
    M_LUI, M_AUIPC, M_JAL, M_JALR,
    M_BEQ, M_BNE, M_BLT, M_BGE, M_BLTU, M_BGEU,
    M_LB, M_LH, M_LW, M_LBU, M_LHU, M_SB, M_SH, M_SW,
    M_ECALL, M_EBREAK, M_FENCE, M_COUNT
  } mn_t;

  always #5 clk = ~clk;

  ex_mem_unit dut (
    .i_Clk         (clk),
    .i_reset       (rst_n),
    .i_pc_addr     (pc),
    .i_inst_data   (inst),
    .i_reg1_data   (rs1),
    .i_reg2_data   (rs2),
    .i_regd_addr   (rd),
    .i_imm_data    (imm),
    .i_ctrl        (ctrl),
    .o_regd_we     (o_we),
    .o_regd_w_addr (o_wa),
    .o_regd_w_data (o_wd),
    .o_hold_flag   (o_hold),
    .o_jump_flag   (o_jmp),
    .o_jump_addr   (o_jaddr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Standard RV32I encoding of a mnemonic (register fields left zero)
  function automatic logic [31:0] enc(input mn_t m, input logic [31:0] im);
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7; logic [4:0] r2; bit it;
    op = 7'h00; f3 = 3'd0; f7 = 7'h00; r2 = 5'd0; it = 1'b0;
    case (m)
      M_ADD:   op = 7'h33;
      M_SUB:   begin op = 7'h33; f7 = 7'h20; end
      M_SLL:   begin op = 7'h33; f3 = 3'd1; end
      M_SLT:   begin op = 7'h33; f3 = 3'd2; end
      M_SLTU:  begin op = 7'h33; f3 = 3'd3; end
      M_XOR:   begin op = 7'h33; f3 = 3'd4; end
      M_SRL:   begin op = 7'h33; f3 = 3'd5; end
      M_SRA:   begin op = 7'h33; f3 = 3'd5; f7 = 7'h20; end
      M_OR:    begin op = 7'h33; f3 = 3'd6; end
      M_AND:   begin op = 7'h33; f3 = 3'd7; end
      M_ADDI:  begin op = 7'h13; it = 1'b1; end
      M_SLTI:  begin op = 7'h13; f3 = 3'd2; it = 1'b1; end
      M_SLTIU: begin op = 7'h13; f3 = 3'd3; it = 1'b1; end
      M_XORI:  begin op = 7'h13; f3 = 3'd4; it = 1'b1; end
      M_ORI:   begin op = 7'h13; f3 = 3'd6; it = 1'b1; end
      M_ANDI:  begin op = 7'h13; f3 = 3'd7; it = 1'b1; end
      M_SLLI:  begin op = 7'h13; f3 = 3'd1; it = 1'b1; end
      M_SRLI:  begin op = 7'h13; f3 = 3'd5; it = 1'b1; end
      M_SRAI:  begin op = 7'h13; f3 = 3'd5; it = 1'b1; end
      M_LUI:   op = 7'h37;
      M_AUIPC: op = 7'h17;
      M_JAL:   op = 7'h6F;
      M_JALR:  begin op = 7'h67; it = 1'b1; end
      M_BEQ:   op = 7'h63;
      M_BNE:   begin op = 7'h63; f3 = 3'd1; end
      M_BLT:   begin op = 7'h63; f3 = 3'd4; end
      M_BGE:   begin op = 7'h63; f3 = 3'd5; end
      M_BLTU:  begin op = 7'h63; f3 = 3'd6; end
      M_BGEU:  begin op = 7'h63; f3 = 3'd7; end
      M_LB:    begin op = 7'h03; it = 1'b1; end
      M_LH:    begin op = 7'h03; f3 = 3'd1; it = 1'b1; end
      M_LW:    begin op = 7'h03; f3 = 3'd2; it = 1'b1; end
      M_LBU:   begin op = 7'h03; f3 = 3'd4; it = 1'b1; end
      M_LHU:   begin op = 7'h03; f3 = 3'd5; it = 1'b1; end
      M_SB:    op = 7'h23;
      M_SH:    begin op = 7'h23; f3 = 3'd1; end
      M_SW:    begin op = 7'h23; f3 = 3'd2; end
      M_ECALL: op = 7'h73;
      M_EBREAK: begin op = 7'h73; r2 = 5'd1; end
      M_FENCE: op = 7'h0F;
      default: op = 7'h00;
    endcase
    if (it) begin
      f7 = im[11:5];
      r2 = im[4:0];
    end
    return {f7, r2, 5'd0, f3, 5'd0, op};
  endfunction

  // Reference behaviour per mnemonic; also applies committed stores to mb
  task automatic model(input mn_t m, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [31:0] p, input logic [4:0] d,
                       input logic v, input logic rs,
                       output logic e_we, output logic [4:0] e_wa, output logic [31:0] e_wd,
                       output logic e_j, output logic [31:0] e_ja, output logic [3:0] e_h);
    logic wr, halt, jmp; logic [31:0] res, tgt, ea, val; int nb, base;
    wr = 1'b0; halt = 1'b0; jmp = 1'b0; res = 32'd0; tgt = 32'd0; val = 32'd0;
    ea = a + im;
    if (v && rs) begin
      case (m)
        M_ADD:   begin wr = 1'b1; res = a + b; end
        M_SUB:   begin wr = 1'b1; res = a - b; end
        M_SLL:   begin wr = 1'b1; res = a << b[4:0]; end
        M_SLT:   begin wr = 1'b1; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        M_SLTU:  begin wr = 1'b1; res = (a < b) ? 32'd1 : 32'd0; end
        M_XOR:   begin wr = 1'b1; res = a ^ b; end
        M_SRL:   begin wr = 1'b1; res = a >> b[4:0]; end
        M_SRA:   begin wr = 1'b1; res = $unsigned($signed(a) >>> b[4:0]); end
        M_OR:    begin wr = 1'b1; res = a | b; end
        M_AND:   begin wr = 1'b1; res = a & b; end
        M_ADDI:  begin wr = 1'b1; res = a + im; end
        M_SLTI:  begin wr = 1'b1; res = ($signed(a) < $signed(im)) ? 32'd1 : 32'd0; end
        M_SLTIU: begin wr = 1'b1; res = (a < im) ? 32'd1 : 32'd0; end
        M_XORI:  begin wr = 1'b1; res = a ^ im; end
        M_ORI:   begin wr = 1'b1; res = a | im; end
        M_ANDI:  begin wr = 1'b1; res = a & im; end
        M_SLLI:  begin wr = 1'b1; res = a << im[4:0]; end
        M_SRLI:  begin wr = 1'b1; res = a >> im[4:0]; end
        M_SRAI:  begin wr = 1'b1; res = $unsigned($signed(a) >>> im[4:0]); end
        M_LUI:   begin wr = 1'b1; res = im; end
        M_AUIPC: begin wr = 1'b1; res = p + im; end
        M_JAL:   begin wr = 1'b1; res = p + 32'd4; jmp = 1'b1; tgt = p + im; end
        M_JALR:  begin wr = 1'b1; res = p + 32'd4; jmp = 1'b1; tgt = ea & 32'hFFFF_FFFE; end
        M_BEQ:   begin jmp = (a == b); tgt = p + im; end
        M_BNE:   begin jmp = (a != b); tgt = p + im; end
        M_BLT:   begin jmp = ($signed(a) < $signed(b)); tgt = p + im; end
        M_BGE:   begin jmp = ($signed(a) >= $signed(b)); tgt = p + im; end
        M_BLTU:  begin jmp = (a < b); tgt = p + im; end
        M_BGEU:  begin jmp = (a >= b); tgt = p + im; end
        M_LB, M_LH, M_LW, M_LBU, M_LHU, M_SB, M_SH, M_SW: begin
          if (m == M_LB || m == M_LBU || m == M_SB) nb = 1;
          else if (m == M_LW || m == M_SW) nb = 4;
          else nb = 2;
          if (MIS_HALT && ((int'(ea[1:0]) % nb) != 0)) begin
            halt = 1'b1;
          end else begin
            base = int'(ea[13:0]) - (int'(ea[1:0]) % nb);
            if (m == M_SB || m == M_SH || m == M_SW) begin
              for (int k = 0; k < nb; k++) mb[base + k] = b[8*k +: 8];
            end else begin
              for (int k = 0; k < nb; k++) val[8*k +: 8] = mb[base + k];
              wr = 1'b1;
              if (m == M_LB) res = {{24{val[7]}}, val[7:0]};
              else if (m == M_LH) res = {{16{val[15]}}, val[15:0]};
              else res = val;
            end
          end
        end
        default: halt = 1'b1;
      endcase
    end
    e_we = wr && (d != 5'd0) && !halt;
    e_wa = e_we ? d : 5'd0;
    e_wd = e_we ? res : 32'd0;
    e_j  = jmp;
    e_ja = jmp ? tgt : 32'd0;
    e_h  = jmp ? 4'b0011 : (halt ? 4'b1101 : 4'b0000);
  endtask

  task automatic step(input string tag, input mn_t m, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] im, input logic [31:0] p, input logic [4:0] d,
                      input logic v, input logic rs);
    logic e_we, e_j; logic [4:0] e_wa; logic [31:0] e_wd, e_ja; logic [3:0] e_h;
    logic [2:0] rsv;
    @(negedge clk);
    rsv   = 3'($urandom_range(0, 7));
    rst_n = rs; pc = p; inst = enc(m, im); rs1 = a; rs2 = b; imm = im; rd = d;
    ctrl  = {rsv, v};
    #1;
    model(m, a, b, im, p, d, v, rs, e_we, e_wa, e_wd, e_j, e_ja, e_h);
    check({tag, ".we"},    32'(o_we),    32'(e_we));
    check({tag, ".waddr"}, 32'(o_wa),    32'(e_wa));
    check({tag, ".wdata"}, o_wd,         e_wd);
    check({tag, ".jump"},  32'(o_jmp),   32'(e_j));
    check({tag, ".jaddr"}, o_jaddr,      e_ja);
    check({tag, ".hold"},  32'(o_hold),  32'(e_h));
  endtask

  function automatic logic [31:0] sext12(input logic [31:0] r);
    return {{20{r[11]}}, r[11:0]};
  endfunction

  initial begin
    rst_n = 1'b0; pc = 32'd0; inst = 32'd0; rs1 = 32'd0; rs2 = 32'd0;
    imm = 32'd0; rd = 5'd0; ctrl = 4'd0;
    repeat (2) @(posedge clk);

    // Reset dominates a valid instruction, then the same ADDI executes
    step("rst_addi", M_ADDI, 32'd0, 32'd0, 32'd5, 32'd0, 5'd1, 1'b1, 1'b0);
    check("rst_we", 32'(o_we), 32'd0);
    step("addi", M_ADDI, 32'd0, 32'd0, 32'd5, 32'd0, 5'd1, 1'b1, 1'b1);
    check("addi_lit", o_wd, 32'd5);

    step("sub", M_SUB, 32'd3, 32'd5, 32'd0, 32'd0, 5'd2, 1'b1, 1'b1);
    check("sub_lit", o_wd, 32'hFFFF_FFFE);
    step("sub_x0", M_SUB, 32'd3, 32'd5, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);
    check("sub_x0_we", 32'(o_we), 32'd0);

    step("sw10", M_SW, 32'h10, 32'hAABB_CCDD, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);
    step("sb12", M_SB, 32'h12, 32'h0000_0011, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);
    step("lw10", M_LW, 32'h10, 32'd0, 32'd0, 32'd0, 5'd3, 1'b1, 1'b1);
    check("lw_lit", o_wd, 32'hAA11_CCDD);
    step("lbu12", M_LBU, 32'h12, 32'd0, 32'd0, 32'd0, 5'd3, 1'b1, 1'b1);
    check("lbu_lit", o_wd, 32'h0000_0011);
    step("sb13", M_SB, 32'h13, 32'h0000_0080, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);
    step("lb13", M_LB, 32'h13, 32'd0, 32'd0, 32'd0, 5'd3, 1'b1, 1'b1);
    check("lb_lit", o_wd, 32'hFFFF_FF80);

    step("beq_t", M_BEQ, 32'd7, 32'd7, 32'd8, 32'h40, 5'd0, 1'b1, 1'b1);
    check("beq_t_addr", o_jaddr, 32'h48);
    check("beq_t_hold", 32'(o_hold), 32'h3);
    step("beq_nt", M_BEQ, 32'd7, 32'd9, 32'd8, 32'h40, 5'd0, 1'b1, 1'b1);
    check("beq_nt_jump", 32'(o_jmp), 32'd0);

    step("jalr", M_JALR, 32'h203, 32'd0, 32'd0, 32'h100, 5'd1, 1'b1, 1'b1);
    check("jalr_addr", o_jaddr, 32'h202);
    check("jalr_rd", o_wd, 32'h104);
    step("ecall", M_ECALL, 32'd0, 32'd0, 32'd0, 32'h104, 5'd0, 1'b1, 1'b1);
    check("ecall_hold", 32'(o_hold), 32'hD);
    step("fence", M_FENCE, 32'd0, 32'd0, 32'd0, 32'h108, 5'd0, 1'b1, 1'b1);

    step("lw13", M_LW, 32'h13, 32'd0, 32'd0, 32'd0, 5'd4, 1'b1, 1'b1);
`ifdef MISALIGN_HALT_EN
    check("lw13_hold", 32'(o_hold), 32'hD);
    check("lw13_we", 32'(o_we), 32'd0);
`else
    check("lw13_data", o_wd, 32'h8011_CCDD);
`endif

    // A bubble must not write RAM
    step("bubble_sw", M_SW, 32'h10, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    step("after_bubble", M_LW, 32'h10, 32'd0, 32'd0, 32'd0, 5'd5, 1'b1, 1'b1);

    // Fill bytes 0..255 through aliased addresses so random loads read known data
    for (int i = 0; i < 64; i++) begin
      logic [31:0] ea, im;
      ea = ($urandom() & 32'hFFFF_C000) | 32'(i * 4);
      im = sext12($urandom());
      step("init_sw", M_SW, ea - im, $urandom(), im, 32'd0, 5'd0, 1'b1, 1'b1);
    end

    for (int n = 0; n < 400; n++) begin
      mn_t m; logic [31:0] a, b, im, p, ea, r; logic v, rs;
      m  = mn_t'($urandom_range(0, int'(M_COUNT) - 1));
      a  = $urandom(); b = $urandom(); r = $urandom();
      p  = $urandom() & 32'hFFFF_FFFC;
      v  = ($urandom_range(0, 9) != 0);
      rs = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 3) == 0) b = a;
      case (m)
        M_SLLI, M_SRLI: im = {27'd0, r[4:0]};
        M_SRAI:         im = 32'h400 | {27'd0, r[4:0]};
        M_LUI, M_AUIPC: im = r & 32'hFFFF_F000;
        M_LB, M_LH, M_LW, M_LBU, M_LHU, M_SB, M_SH, M_SW: begin
          ea = $urandom() & 32'hFFFF_C0FF;
          im = sext12(r);
          a  = ea - im;
        end
        default:        im = sext12(r) & 32'hFFFF_FFFE;
      endcase
      step("rand", m, a, b, im, p, 5'($urandom_range(0, 31)), v, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
